spi_word_frame_ctrl: RTL and testbench

//  Frame controller between the SPI peripheral byte interface and the on-chip parameter/weight register bank.

---
 rtl/spi_word_frame_ctrl.sv | 166 ++++++++++++++++
 tb/tb_spi_word_frame_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_frame_ctrl.sv
// SPI word frame controller: header decode, 32-bit word writes and
// byte-sequenced word reads against the parameter register bank.
module spi_word_frame_ctrl #(
  parameter int ADDR_W    = 7,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  output logic                 tx_load,
  output logic [7:0]           tx_byte,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [31:0]          wr_data,
  output logic                 rd_req,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic                 rd_valid,
  input  logic [31:0]          rd_data,
  output logic                 busy,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    WPEND,
    RREQ,
    RWAIT,
    RSEND
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr;
  logic [23:0]       shift;
  logic              rd_abort;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= 2'd0;
      addr      <= '0;
      shift     <= 24'd0;
      rd_abort  <= 1'b0;
      tx_load   <= 1'b0;
      tx_byte   <= 8'd0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 32'd0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      tx_load   <= 1'b0;
      rd_req    <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          byte_cnt <= 2'd0;
          if (!ss) state <= HDR;
        end
        HDR: begin
          if (ss) begin
            state <= IDLE;
          end else if (rx_valid) begin
            addr     <= rx_byte[ADDR_W-1:0];
            byte_cnt <= 2'd0;
            state    <= rx_byte[7] ? RREQ : WDATA;
          end
        end
        WDATA: begin
          if (rx_valid) begin
            shift    <= {shift[15:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // a word completed together with ss rise is still written
              wr_data  <= {shift, rx_byte};
              wr_addr  <= addr;
              wr_valid <= 1'b1;
              state    <= WPEND;
            end else if (ss) begin
              byte_cnt  <= 2'd0;
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (ss) begin
            byte_cnt  <= 2'd0;
            frame_err <= (byte_cnt != 2'd0);
            state     <= IDLE;
          end
        end
        WPEND: begin
          if (rx_valid) frame_err <= 1'b1;
          if (wr_ready) begin
            wr_valid <= 1'b0;
            addr     <= addr + ADDR_W'(1);
            state    <= ss ? IDLE : WDATA;
          end
        end
        RREQ: begin
          rd_req   <= 1'b1;
          rd_addr  <= addr;
          rd_abort <= ss;
          state    <= RWAIT;
        end
        RWAIT: begin
          if (ss) rd_abort <= 1'b1;
          if (rd_valid) begin
            shift    <= rd_data[23:0];
            byte_cnt <= 2'd0;
            rd_abort <= 1'b0;
            if (rd_abort || ss) begin
              state <= IDLE;
            end else begin
              tx_byte <= rd_data[31:24];
              tx_load <= 1'b1;
              state   <= RSEND;
            end
          end
        end
        RSEND: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr  <= addr + ADDR_W'(1);
              state <= ss ? IDLE : RREQ;
            end else begin
              tx_load <= 1'b1;
              if (byte_cnt == 2'd0)
                tx_byte <= shift[23:16];
              else if (byte_cnt == 2'd1)
                tx_byte <= shift[15:8];
              else
                tx_byte <= shift[7:0];
              if (ss) begin
                byte_cnt  <= 2'd0;
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end
          end else if (ss) begin
            byte_cnt  <= 2'd0;
            frame_err <= (byte_cnt != 2'd0);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (frame_err && (err_count != '1))
      err_count <= err_count + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_spi_word_frame_ctrl.sv
// Directed bench for spi_word_frame_ctrl: writes, bursts, reads,
// truncation, overrun while a write is pending, and mid-frame reset.
module tb_spi_word_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        tx_load;
  logic [7:0]  tx_byte;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_data = 32'd0;
  logic        busy;
  logic        frame_err;
  logic [7:0]  err_count;

  int vecs = 0;
  int errs = 0;

  logic [6:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  tx_q[$];
  int          rd_n;
  int          fe_n;

  spi_word_frame_ctrl #(.ADDR_W(7), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ss(ss),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_load(tx_load), .tx_byte(tx_byte),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .frame_err(frame_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (tx_load) tx_q.push_back(tx_byte);
      if (rd_req) rd_n++;
      if (frame_err) fe_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    tx_q.delete();
    rd_n = 0;
    fe_n = 0;
  endtask

  task automatic test_reset();
    tick(3);
    @(negedge clk);
    vecs++;
    if ({tx_load, wr_valid, rd_req, busy, frame_err} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags got %b exp 00000",
               {tx_load, wr_valid, rd_req, busy, frame_err});
    end
    vecs++;
    if ({tx_byte, wr_addr, rd_addr, err_count} !== 30'd0) begin
      errs++;
      $display("FAIL reset_fields got %h exp 0",
               {tx_byte, wr_addr, rd_addr, err_count});
    end
    vecs++;
    if (wr_data !== 32'd0) begin
      errs++;
      $display("FAIL reset_wr_data got %h exp 0", wr_data);
    end
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write();
    clr();
    ss = 1'b0;
    tick(2);
    send(8'h05);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    tick(2);
    ss = 1'b1;
    tick(3);
    @(negedge clk);
    vecs++;
    if (wa_q.size() !== 1) begin
      errs++;
      $display("FAIL write_count got %0d exp 1", wa_q.size());
    end
    vecs++;
    if (wa_q[0] !== 7'h05) begin
      errs++;
      $display("FAIL write_addr got %h exp 05", wa_q[0]);
    end
    vecs++;
    if (wd_q[0] !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL write_data got %h exp deadbeef", wd_q[0]);
    end
    vecs++;
    if (fe_n !== 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL write_end got fe=%0d busy=%b exp 0 0", fe_n, busy);
    end
  endtask

  task automatic test_burst();
    clr();
    ss = 1'b0;
    tick(2);
    send(8'h10);
    for (int i = 1; i <= 8; i++) send(8'(i));
    tick(2);
    ss = 1'b1;
    tick(3);
    vecs++;
    if (wa_q.size() !== 2) begin
      errs++;
      $display("FAIL burst_count got %0d exp 2", wa_q.size());
    end
    vecs++;
    if (wa_q[0] !== 7'h10 || wd_q[0] !== 32'h01020304) begin
      errs++;
      $display("FAIL burst_w0 got %h/%h exp 10/01020304", wa_q[0], wd_q[0]);
    end
    vecs++;
    if (wa_q[1] !== 7'h11 || wd_q[1] !== 32'h05060708) begin
      errs++;
      $display("FAIL burst_w1 got %h/%h exp 11/05060708", wa_q[1], wd_q[1]);
    end
  endtask

  task automatic test_read();
    logic [7:0] exp_tx[4];
    exp_tx = '{8'h12, 8'h34, 8'h56, 8'h78};
    clr();
    ss = 1'b0;
    tick(2);
    rx_byte = 8'h83;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (rd_req !== 1'b0) begin
      errs++;
      $display("FAIL read_req_early got %b exp 0", rd_req);
    end
    tick(1);
    @(negedge clk);
    vecs++;
    if (rd_req !== 1'b1 || rd_addr !== 7'h03) begin
      errs++;
      $display("FAIL read_req got %b/%h exp 1/03", rd_req, rd_addr);
    end
    tick(3);
    rd_valid = 1'b1;
    rd_data = 32'h12345678;
    tick(1);
    rd_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (tx_load !== 1'b1 || tx_byte !== 8'h12) begin
      errs++;
      $display("FAIL read_first got %b/%h exp 1/12", tx_load, tx_byte);
    end
    tick(1);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    rx_byte = 8'h00;
    rx_valid = 1'b1;
    ss = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(3);
    vecs++;
    if (rd_n !== 1 || tx_q.size() !== 4) begin
      errs++;
      $display("FAIL read_counts got rd=%0d tx=%0d exp 1 4", rd_n, tx_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (tx_q[i] !== exp_tx[i]) begin
        errs++;
        $display("FAIL read_tx%0d got %h exp %h", i, tx_q[i], exp_tx[i]);
      end
    end
    vecs++;
    if (fe_n !== 0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL read_end got fe=%0d busy=%b exp 0 0", fe_n, busy);
    end
  endtask

  task automatic test_trunc();
    clr();
    ss = 1'b0;
    tick(2);
    send(8'h02);
    send(8'hAA);
    send(8'hBB);
    ss = 1'b1;
    tick(3);
    @(negedge clk);
    vecs++;
    if (wa_q.size() !== 0) begin
      errs++;
      $display("FAIL trunc_writes got %0d exp 0", wa_q.size());
    end
    vecs++;
    if (fe_n !== 1 || err_count !== 8'd1) begin
      errs++;
      $display("FAIL trunc_err got fe=%0d cnt=%0d exp 1 1", fe_n, err_count);
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL trunc_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_wpend();
    clr();
    wr_ready = 1'b0;
    ss = 1'b0;
    tick(2);
    send(8'h20);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rx_byte = 8'h44;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        rx_byte = 8'h55;
        rx_valid = 1'b1;
      end
      @(negedge clk);
      vecs++;
      if (wr_valid !== 1'b1 || wr_addr !== 7'h20 ||
          wr_data !== 32'h11223344) begin
        errs++;
        $display("FAIL wpend_hold%0d got %b/%h/%h exp 1/20/11223344",
                 i, wr_valid, wr_addr, wr_data);
      end
      tick(1);
      rx_valid = 1'b0;
    end
    wr_ready = 1'b1;
    tick(1);
    ss = 1'b1;
    tick(3);
    vecs++;
    if (wa_q.size() !== 1 || wd_q[0] !== 32'h11223344) begin
      errs++;
      $display("FAIL wpend_write got n=%0d d=%h exp 1 11223344",
               wa_q.size(), wd_q[0]);
    end
    vecs++;
    if (fe_n !== 1 || err_count !== 8'd2) begin
      errs++;
      $display("FAIL wpend_err got fe=%0d cnt=%0d exp 1 2", fe_n, err_count);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    ss = 1'b0;
    tick(2);
    send(8'h07);
    send(8'h01);
    send(8'h02);
    rx_byte = 8'h03;
    rx_valid = 1'b1;
    rst = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    ss = 1'b1;
    @(negedge clk);
    vecs++;
    if ({tx_load, wr_valid, rd_req, busy, frame_err} !== 5'b0) begin
      errs++;
      $display("FAIL rstmid_flags got %b exp 00000",
               {tx_load, wr_valid, rd_req, busy, frame_err});
    end
    vecs++;
    if (wr_data !== 32'd0 || err_count !== 8'd0 || wr_addr !== 7'd0) begin
      errs++;
      $display("FAIL rstmid_regs got %h/%0d/%h exp 0", wr_data, err_count,
               wr_addr);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    clr();
    ss = 1'b0;
    tick(2);
    send(8'h09);
    send(8'hCA);
    send(8'hFE);
    send(8'hBA);
    send(8'hBE);
    tick(2);
    ss = 1'b1;
    tick(3);
    vecs++;
    if (wa_q.size() !== 1 || wa_q[0] !== 7'h09 ||
        wd_q[0] !== 32'hCAFEBABE) begin
      errs++;
      $display("FAIL rstmid_write got n=%0d a=%h d=%h exp 1 09 cafebabe",
               wa_q.size(), wa_q[0], wd_q[0]);
    end
    vecs++;
    if (fe_n !== 0) begin
      errs++;
      $display("FAIL rstmid_err got %0d exp 0", fe_n);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_write();
    test_burst();
    test_read();
    test_trunc();
    test_wpend();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
